sti_pixel_writer: RTL and testbench

- Downstream stage of the serial transmitter: consumes its so_data/so_valid bit stream and packs the bits MSB-first into 8-bit pixels.
- Writes each pixel to a 256-entry pixel memory with sequential addresses.
- At frame end, flushes any partial byte and pads the unwritten tail of memory.
- Holds pixel_finish high once the memory image is complete.

---
 rtl/sti_pkg.sv | 19 +
 rtl/sti_pixel_writer_if.sv | 30 +++
 rtl/sti_bit_packer.sv | 50 +++++
 rtl/sti_pixel_writer.sv | 144 ++++++++++++++
 tb/tb_sti_pixel_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sti_pkg.sv
// sti_pkg: shared types and defaults for the serial-to-pixel writer.
//   state_t        : writer FSM states
//   ADDR_W         : pixel address width
//   MEM_DEPTH      : number of pixel addresses (2**ADDR_W)
//   FILL_VALUE_DEF : default pad value for partial bytes and tail fill
package sti_pkg;

  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam logic [7:0] FILL_VALUE_DEF = 8'h00;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sti_pixel_writer_if.sv
// sti_pixel_writer_if: serial input stream and pixel-memory write port.
//   so_valid, so_data, frame_end : serial bit stream from the transmitter
//   pixel_wr, pixel_addr,
//   pixel_dataout                : pixel memory write port
//   pixel_finish                 : image-complete flag
// modport slave  : the pixel writer
// modport master : the bit source / memory side
interface sti_pixel_writer_if #(
  parameter int ADDR_W = 8
);

  logic              so_valid;
  logic              so_data;
  logic              frame_end;
  logic              pixel_wr;
  logic [ADDR_W-1:0] pixel_addr;
  logic [7:0]        pixel_dataout;
  logic              pixel_finish;

  modport slave (
    input  so_valid, so_data, frame_end,
    output pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );

  modport master (
    output so_valid, so_data, frame_end,
    input  pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );

endinterface

// File: rtl/sti_bit_packer.sv
// sti_bit_packer: MSB-first shift register with a mod-8 bit counter.
//   clk, reset    : clock, synchronous active-high reset
//   clear         : synchronous clear of shift register and bit count
//   bit_valid     : capture bit_data this cycle
//   bit_data      : serial bit
//   byte_done     : this cycle's capture completes a byte
//   byte_data     : the completed byte (valid with byte_done)
//   partial_next  : bit count after this cycle's capture is non-zero
//   partial_byte  : captured bits left-aligned, LSBs padded from FILL_VALUE
module sti_bit_packer #(
  parameter logic [7:0] FILL_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       partial_next,
  output logic [7:0] partial_byte
);

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [3:0] pad_w;
  logic [7:0] keep_mask;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (bit_valid) begin
      shift   <= {shift[6:0], bit_data};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_comb begin
    byte_done    = bit_valid && (bit_cnt == 3'd7);
    byte_data    = {shift[6:0], bit_data};
    partial_next = bit_valid ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0);
    // The low bit_cnt bits of shift are the received bits; shift them to
    // the top and take the remaining LSBs from the pad value.
    pad_w        = 4'd8 - {1'b0, bit_cnt};
    keep_mask    = 8'hFF << pad_w;
    partial_byte = ((shift << pad_w) & keep_mask) | (FILL_VALUE & ~keep_mask);
  end

endmodule

// File: rtl/sti_pixel_writer.sv
// sti_pixel_writer: packs a serial bit stream MSB-first into 8-bit pixels,
// writes them to sequential pixel addresses, flushes a partial byte at
// frame end, optionally pads the memory tail, then raises pixel_finish.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sti_pixel_writer_if.slave (serial input, pixel write port)
// Build option STI_PIXEL_FILL_EN: when defined, unwritten addresses are
// filled with FILL_VALUE after the frame; otherwise FILL is bypassed.
//
// state | meaning
// RECV  | capture bits, write each completed byte
// FLUSH | write the left-aligned partial byte
// FILL  | write FILL_VALUE until byte_cnt reaches MEM_DEPTH
// DONE  | pixel_finish held high until reset
module sti_pixel_writer #(
  parameter int         MEM_DEPTH  = sti_pkg::MEM_DEPTH,
  parameter int         ADDR_W     = sti_pkg::ADDR_W,
  parameter logic [7:0] FILL_VALUE = sti_pkg::FILL_VALUE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  sti_pixel_writer_if.slave    bus
);

  import sti_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state;
  logic [ADDR_W:0]   byte_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              pixel_wr_q;
  logic [ADDR_W-1:0] pixel_addr_q;
  logic [7:0]        pixel_data_q;
  logic              pixel_finish_q;

  logic              bit_cap;
  logic              byte_done;
  logic [7:0]        byte_data;
  logic              partial_next;
  logic [7:0]        partial_byte;

  assign bit_cap = bus.so_valid && (state == RECV);

  sti_bit_packer #(
    .FILL_VALUE (FILL_VALUE)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (state == FLUSH),
    .bit_valid    (bit_cap),
    .bit_data     (bus.so_data),
    .byte_done    (byte_done),
    .byte_data    (byte_data),
    .partial_next (partial_next),
    .partial_byte (partial_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RECV;
      byte_cnt       <= '0;
      wr_addr        <= '0;
      pixel_wr_q     <= 1'b0;
      pixel_addr_q   <= '0;
      pixel_data_q   <= 8'h00;
      pixel_finish_q <= 1'b0;
    end else begin
      pixel_wr_q <= 1'b0;
      case (state)
        RECV: begin
          if (byte_done) begin
            pixel_wr_q   <= 1'b1;
            pixel_addr_q <= wr_addr;
            pixel_data_q <= byte_data;
            // Address wraps on overflow; byte_cnt saturates so that FILL
            // sees a full memory.
            wr_addr      <= wr_addr + 1'b1;
            if (byte_cnt != DEPTH_CNT)
              byte_cnt <= byte_cnt + 1'b1;
          end
          if (bus.frame_end) begin
            if (partial_next) begin
              state <= FLUSH;
            end else begin
`ifdef STI_PIXEL_FILL_EN
              state <= FILL;
`else
              // A byte written on this edge delays finish by one cycle;
              // DONE raises it on the following edge.
              state          <= DONE;
              pixel_finish_q <= !byte_done;
`endif
            end
          end
        end

        FLUSH: begin
          pixel_wr_q   <= 1'b1;
          pixel_addr_q <= wr_addr;
          pixel_data_q <= partial_byte;
          wr_addr      <= wr_addr + 1'b1;
          if (byte_cnt != DEPTH_CNT)
            byte_cnt <= byte_cnt + 1'b1;
`ifdef STI_PIXEL_FILL_EN
          state <= FILL;
`else
          state <= DONE;
`endif
        end

        FILL: begin
`ifdef STI_PIXEL_FILL_EN
          if (byte_cnt != DEPTH_CNT) begin
            pixel_wr_q   <= 1'b1;
            pixel_addr_q <= byte_cnt[ADDR_W-1:0];
            pixel_data_q <= FILL_VALUE;
            byte_cnt     <= byte_cnt + 1'b1;
          end else begin
            state          <= DONE;
            pixel_finish_q <= 1'b1;
          end
`else
          state          <= DONE;
          pixel_finish_q <= 1'b1;
`endif
        end

        DONE: begin
          pixel_finish_q <= 1'b1;
        end

        default: begin
          state <= RECV;
        end
      endcase
    end
  end

  assign bus.pixel_wr      = pixel_wr_q;
  assign bus.pixel_addr    = pixel_addr_q;
  assign bus.pixel_dataout = pixel_data_q;
  assign bus.pixel_finish  = pixel_finish_q;

endmodule

// File: tb/tb_sti_pixel_writer.sv
// tb_sti_pixel_writer: directed bench for sti_pixel_writer. Expectations
// follow the STI_PIXEL_FILL_EN setting of the build.
module tb_sti_pixel_writer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sti_pixel_writer_if #(.ADDR_W(8)) bus ();

  sti_pixel_writer #(
    .MEM_DEPTH  (256),
    .ADDR_W     (8),
    .FILL_VALUE (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  bit  fin_seen = 1'b0;
  int  fin_cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pixel_wr === 1'b1)
      wq.push_back('{cyc, bus.pixel_addr, bus.pixel_dataout});
    if (bus.pixel_finish === 1'b1 && !fin_seen) begin
      fin_seen = 1'b1;
      fin_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fe);
    bus.so_valid  = 1'b1;
    bus.so_data   = b;
    bus.frame_end = fe;
    tick();
    bus.so_valid  = 1'b0;
    bus.so_data   = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic fe_last);
    for (int i = 7; i >= 0; i--)
      send_bit(v[i], fe_last && (i == 0));
  endtask

  task automatic pulse_fe();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wq.delete();
    fin_seen = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    int n;
    n = 0;
    while (!fin_seen && n < budget) begin
      tick();
      n++;
    end
    if (!fin_seen) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bus.so_valid  = 1'b0;
    bus.so_data   = 1'b0;
    bus.frame_end = 1'b0;
    reset         = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_wr",     bus.pixel_wr,      0);
    check("rst_addr",   bus.pixel_addr,    0);
    check("rst_data",   bus.pixel_dataout, 0);
    check("rst_finish", bus.pixel_finish,  0);
    reset = 1'b0;
    wq.delete();

    // Single byte 0xA5, write visible right after the 8th bit edge
    send_byte(8'hA5, 1'b0);
    check("a5_wr",   bus.pixel_wr,      1);
    check("a5_addr", bus.pixel_addr,    8'h00);
    check("a5_data", bus.pixel_dataout, 8'hA5);
    tick();
    check("a5_wr_off", bus.pixel_wr, 0);
    repeat (3) tick();
    check("a5_count", wq.size(), 1);

    // Back-to-back bytes, writes exactly 8 cycles apart
    do_reset();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (3) tick();
    check("b2b_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("b2b_addr0", wq[0].addr, 8'h00);
      check("b2b_data0", wq[0].data, 8'h3C);
      check("b2b_addr1", wq[1].addr, 8'h01);
      check("b2b_data1", wq[1].data, 8'hFF);
      check("b2b_gap",   wq[1].cyc - wq[0].cyc, 8);
    end

    // 11 bits with frame_end on the last bit: flush 0xC0
    do_reset();
    send_byte(8'hC3, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    wait_finish("flush_finish_timeout", 600);
    repeat (3) tick();
`ifdef STI_PIXEL_FILL_EN
    check("flush_count", wq.size(), 256);
`else
    check("flush_count", wq.size(), 2);
`endif
    if (wq.size() >= 2) begin
      check("flush_addr0", wq[0].addr, 8'h00);
      check("flush_data0", wq[0].data, 8'hC3);
      check("flush_addr1", wq[1].addr, 8'h01);
      check("flush_data1", wq[1].data, 8'hC0);
      check("flush_last_addr", wq[wq.size()-1].addr, wq.size() == 256 ? 8'hFF : 8'h01);
      check("flush_fin_lat", fin_cyc - wq[wq.size()-1].cyc, 1);
      bad = 0;
      for (int i = 2; i < wq.size(); i++)
        if (wq[i].addr != 8'(i) || wq[i].data != 8'h00) bad++;
      check("flush_tail_fill", bad, 0);
    end
    check("flush_finish_hold", bus.pixel_finish, 1);

    // frame_end with nothing received
    do_reset();
    pulse_fe();
`ifdef STI_PIXEL_FILL_EN
    wait_finish("empty_finish_timeout", 600);
    check("empty_count", wq.size(), 256);
    if (wq.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wq[i].addr != 8'(i) || wq[i].data != 8'h00) bad++;
      check("empty_fill_seq", bad, 0);
      check("empty_fill_span", wq[255].cyc - wq[0].cyc, 255);
    end
`else
    check("empty_finish_next", bus.pixel_finish, 1);
    repeat (4) tick();
    check("empty_count", wq.size(), 0);
`endif

    // 257 bytes: the last one wraps to address 0x00, no tail fill
    do_reset();
    for (int b = 0; b < 256; b++)
      send_byte(8'(b), 1'b0);
    send_byte(8'h5A, 1'b0);
    pulse_fe();
    wait_finish("full_finish_timeout", 50);
    repeat (4) tick();
    check("full_count", wq.size(), 257);
    if (wq.size() == 257) begin
      check("full_addr255", wq[255].addr, 8'hFF);
      check("full_data255", wq[255].data, 8'hFF);
      check("wrap_addr",    wq[256].addr, 8'h00);
      check("wrap_data",    wq[256].data, 8'h5A);
    end
    check("full_finish", bus.pixel_finish, 1);
    // Inputs ignored once done
    wq.delete();
    send_byte(8'h11, 1'b0);
    repeat (2) tick();
    check("done_ignores_input", wq.size(), 0);

    // Reset in mid-operation
    do_reset();
`ifdef STI_PIXEL_FILL_EN
    pulse_fe();
    bad = 1;
    for (int n = 0; n < 400 && bad == 1; n++) begin
      if (bus.pixel_wr === 1'b1 && bus.pixel_addr === 8'h40) bad = 0;
      else tick();
    end
    check("mid_reach_0x40", bad, 0);
`else
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`endif
    reset = 1'b1;
    tick();
    check("mid_rst_wr",     bus.pixel_wr,     0);
    check("mid_rst_addr",   bus.pixel_addr,   0);
    check("mid_rst_finish", bus.pixel_finish, 0);
    reset = 1'b0;
    wq.delete();
    fin_seen = 1'b0;
    repeat (5) tick();
    check("mid_no_writes", wq.size(), 0);
    send_byte(8'h99, 1'b0);
    repeat (2) tick();
    check("mid_new_count", wq.size(), 1);
    if (wq.size() == 1) begin
      check("mid_new_addr", wq[0].addr, 8'h00);
      check("mid_new_data", wq[0].data, 8'h99);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
